// File: rtl/display_arbiter.sv
// Fixed-priority owner arbiter for a shared 8x8 matrix / 8-digit / buzzer display, with minimum-hold preemption.
// Define DISP_ARB_GAP_EN to insert a GAP_CYC-cycle blank gap on every ownership change.
module display_arbiter #(
  parameter int MIN_HOLD = 1000,
  parameter int GAP_CYC  = 4
) (
  input  logic         clk,
  input  logic         sw,
  input  logic [2:0]   req,
  input  logic [127:0] matrix0,
  input  logic [127:0] matrix1,
  input  logic [127:0] matrix2,
  input  logic [31:0]  num0,
  input  logic [31:0]  num1,
  input  logic [31:0]  num2,
  input  logic         beep0,
  input  logic         beep1,
  input  logic         beep2,
  output logic [2:0]   grant,
  output logic [127:0] matrixData,
  output logic [31:0]  numbersData,
  output logic         beep,
  output logic         busy
);

  localparam int HW = $clog2(MIN_HOLD + 1);

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("display_arbiter: GAP_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

  state_e          state_q;
  logic [2:0]      grant_q;
  logic [HW-1:0]   hold_q;
`ifdef DISP_ARB_GAP_EN
  localparam int GW = $clog2(GAP_CYC + 1);
  logic [GW-1:0]   gap_q;
`endif

  // Lowest index set wins.
  function automatic logic [2:0] pick(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  logic       owner_req, hold_full, release_c, preempt_c;
  logic [2:0] higher;

  assign owner_req = |(req & grant_q);
  // grant_q is one-hot, so grant_q-1 masks exactly the higher-priority sources.
  assign higher    = req & (grant_q - 3'd1);
  assign hold_full = (hold_q == HW'(MIN_HOLD));
  // A dropped owner request is a release even if a higher source rose alongside it.
  assign release_c = !owner_req;
  assign preempt_c = owner_req && hold_full && (|higher);

`ifndef DISP_ARB_GAP_EN
  logic [2:0] next_owner;
  assign next_owner = pick(release_c ? (req & ~grant_q) : req);
`endif

  always_ff @(posedge clk or negedge sw) begin
    if (!sw) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      hold_q  <= '0;
`ifdef DISP_ARB_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          state_q <= OWN;
          grant_q <= pick(req);
          hold_q  <= '0;
        end
        OWN: begin
          if (release_c || preempt_c) begin
            hold_q <= '0;
`ifdef DISP_ARB_GAP_EN
            state_q <= GAP;
            grant_q <= 3'b000;
            gap_q   <= '0;
`else
            grant_q <= next_owner;
            state_q <= (|next_owner) ? OWN : IDLE;
`endif
          end else if (!hold_full) begin
            hold_q <= hold_q + HW'(1);
          end
        end
`ifdef DISP_ARB_GAP_EN
        GAP: begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            gap_q   <= '0;
            hold_q  <= '0;
            grant_q <= pick(req);
            state_q <= (|req) ? OWN : IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          grant_q <= 3'b000;
          hold_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    matrixData  = '0;
    numbersData = 32'hFFFF_FFFF;
    beep        = 1'b0;
    case (grant_q)
      3'b001: begin matrixData = matrix0; numbersData = num0; beep = beep0; end
      3'b010: begin matrixData = matrix1; numbersData = num1; beep = beep1; end
      3'b100: begin matrixData = matrix2; numbersData = num2; beep = beep2; end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (MIN_HOLD=8, GAP_CYC=2); expectations follow the gap macro when defined.
module tb_display_arbiter;

`ifdef DISP_ARB_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic         clk = 1'b0;
  logic         sw;
  logic [2:0]   req;
  logic [127:0] matrix0, matrix1, matrix2;
  logic [31:0]  num0, num1, num2;
  logic         beep0, beep1, beep2;
  logic [2:0]   grant;
  logic [127:0] matrixData;
  logic [31:0]  numbersData;
  logic         beep, busy;

  int checks = 0;
  int errors = 0;

  display_arbiter #(.MIN_HOLD(8), .GAP_CYC(2)) dut (
    .clk(clk), .sw(sw), .req(req),
    .matrix0(matrix0), .matrix1(matrix1), .matrix2(matrix2),
    .num0(num0), .num1(num1), .num2(num2),
    .beep0(beep0), .beep1(beep1), .beep2(beep2),
    .grant(grant), .matrixData(matrixData), .numbersData(numbersData),
    .beep(beep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req = 3'b000;
    tick();
    repeat (GAP) tick();
  endtask

  task automatic test_reset();
    sw = 1'b0; req = 3'b000;
    #3;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b exp 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tick();
    sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || numbersData !== 32'hFFFF_FFFF ||
          matrixData !== 128'd0 || beep !== 1'b0) begin
        errors++;
        $display("FAIL idle_blank cyc %0d: got grant=%b busy=%b num=%h beep=%b exp 000/0/ffffffff/0",
                 i, grant, busy, numbersData, beep);
      end
    end
  endtask

  task automatic test_priority();
    req = 3'b110;
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL prio_grant: got %b exp 010", grant); end
    checks++; if (matrixData !== matrix1) begin errors++; $display("FAIL prio_matrix: got %h exp %h", matrixData, matrix1); end
    checks++; if (numbersData !== num1 || beep !== beep1) begin errors++; $display("FAIL prio_num_beep: got %h/%b exp %h/%b", numbersData, beep, num1, beep1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b exp 1", busy); end
    req = 3'b000;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL prio_release: got %b exp 000", grant); end
    repeat (GAP) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_preempt();
    req = 3'b100;
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL pre_own2: got %b exp 100", grant); end
    tick(); tick(); tick();
    req = 3'b101;
    // Edges 4..8 after grant must not switch; hold reaches 8 at edge 8.
    for (int i = 4; i <= 8; i++) begin
      tick();
      checks++; if (grant !== 3'b100) begin errors++; $display("FAIL pre_hold edge %0d: got %b exp 100", i, grant); end
    end
    for (int i = 0; i < GAP; i++) begin
      tick();
      checks++;
      if (grant !== 3'b000 || matrixData !== 128'd0 || numbersData !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL pre_gap %0d: got grant=%b num=%h exp 000/ffffffff", i, grant, numbersData);
      end
    end
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL pre_switch: got %b exp 001", grant); end
    checks++; if (numbersData !== num0) begin errors++; $display("FAIL pre_num0: got %h exp %h", numbersData, num0); end
    go_idle();
  endtask

  task automatic test_no_lower_preempt();
    req = 3'b001;
    tick();
    req = 3'b011;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lower_preempt cyc %0d: got %b exp 001", i, grant); end
    end
    go_idle();
  endtask

  task automatic test_release();
    req = 3'b001;
    tick();
    tick(); tick();
    req = 3'b100;
    for (int i = 0; i < GAP; i++) begin
      tick();
      checks++; if (grant !== 3'b000 || beep !== 1'b0) begin errors++; $display("FAIL rel_gap %0d: got %b/%b exp 000/0", i, grant, beep); end
    end
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rel_next: got %b exp 100", grant); end
    checks++; if (matrixData !== matrix2) begin errors++; $display("FAIL rel_matrix: got %h exp %h", matrixData, matrix2); end
    go_idle();
  endtask

  task automatic test_simultaneous();
    req = 3'b010;
    tick(); tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL sim_own1: got %b exp 010", grant); end
    req = 3'b001;
    repeat (GAP) tick();
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL sim_next: got %b exp 001", grant); end
    // Owner 0 with req2 raised must keep grant: a fresh hold counter is irrelevant to lower sources.
    req = 3'b101;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL sim_keep: got %b exp 001", grant); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    req = 3'b100;
    tick(); tick(); tick();
    #2 sw = 1'b0;
    #1;
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rst_own: got %b/%b exp 000/0", grant, busy); end
    checks++; if (numbersData !== 32'hFFFF_FFFF || matrixData !== 128'd0) begin errors++; $display("FAIL rst_own_blank: got %h exp ffffffff", numbersData); end
    req = 3'b010;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_held: got %b exp 000", grant); end
    sw = 1'b1;
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rst_resume: got %b exp 010", grant); end
`ifdef DISP_ARB_GAP_EN
    req = 3'b000;
    tick();
    checks++; if (busy !== 1'b1 || grant !== 3'b000) begin errors++; $display("FAIL rst_gap_enter: got %b/%b exp 1/000", busy, grant); end
    #2 sw = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_gap: got %b exp 0", busy); end
    req = 3'b010;
    tick();
    sw = 1'b1;
    tick();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rst_gap_resume: got %b exp 010", grant); end
`endif
    go_idle();
  endtask

  initial begin
    matrix0 = {4{32'hA0A0_0001}}; matrix1 = {4{32'hB1B1_0002}}; matrix2 = {4{32'hC2C2_0004}};
    num0 = 32'h0000_0123; num1 = 32'h1111_4567; num2 = 32'h2222_89AB;
    beep0 = 1'b1; beep1 = 1'b0; beep2 = 1'b1;
    sw = 1'b0; req = 3'b000;
    test_reset();
    test_priority();
    test_preempt();
    test_no_lower_preempt();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have parameter MIN_HOLD, default 1000, the minimum number of owned cycles before a higher-priority requester may preempt the current owner.
REQ-002 The block SHALL have parameter GAP_CYC, default 4, the length in cycles of the blanking gap (used only with DISP_ARB_GAP_EN).
REQ-003 The block SHALL have port clk  input  1  system clock; all state on posedge.
REQ-004 The block SHALL have port sw  input  1  main switch; asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  3  request per source; index 0 is highest priority, index 2 is lowest.
REQ-006 The block SHALL have ports matrix0/matrix1/matrix2  input  128 each  per-source 8x8 RG matrix data.
REQ-007 The block SHALL have ports num0/num1/num2  input  32 each  per-source 8-digit nibble data.
REQ-008 The block SHALL have ports beep0/beep1/beep2  input  1 each  per-source buzzer drive.
REQ-009 The block SHALL have port grant  output  3  one-hot registered current owner; 0 means no owner.
REQ-010 The block SHALL have ports matrixData  output  128, numbersData  output  32, and beep  output  1, which carry the muxed shared display outputs.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, OWN and GAP.
REQ-013 When grant is 0, the outputs SHALL be blank: matrixData = 0, numbersData = 32'hFFFF_FFFF (all digits hidden), beep = 0.
REQ-014 When grant is nonzero, the outputs SHALL be a combinational mux of the owner's matrix, num and beep, with zero added latency from grant.
REQ-015 In IDLE, if any req is high at a clk edge, grant SHALL go to the highest-priority requester at that edge, state SHALL become OWN, and the hold counter SHALL clear to 0.
REQ-016 In OWN, the hold counter SHALL increment each cycle and saturate at MIN_HOLD; its width is clog2(MIN_HOLD+1).
REQ-017 Release: in OWN, if the owner's req is low at an edge, the owner SHALL lose grant at that edge regardless of the hold count.
REQ-018 Preempt: in OWN, with the owner's req still high and hold counter == MIN_HOLD, a higher-priority req SHALL take ownership at that edge.
REQ-019 Before MIN_HOLD is reached, preemption SHALL NOT occur; a lower-priority req SHALL never preempt.
REQ-020 If the owner drops req and a higher-priority req rises in the same cycle, this SHALL be handled as a release (REQ-017).
REQ-021 Without a gap, the next owner on release or preempt SHALL be the highest-priority pending req excluding a releasing owner; if none, state SHALL become IDLE with grant 0.
REQ-022 On every ownership change, the hold counter SHALL restart at 0.
REQ-023 In IDLE with req = 0, the state and all outputs SHALL stay unchanged.

Reset
REQ-024 sw low SHALL immediately force state IDLE, grant 0, busy 0, hold and gap counters 0, and the blank outputs of REQ-013, including mid-OWN or mid-GAP.
REQ-025 After sw rises, arbitration SHALL resume on the first clk edge where req is nonzero.

Configuration
REQ-026 With macro DISP_ARB_GAP_EN defined, every release or preempt SHALL enter GAP with grant 0 and blank outputs for exactly GAP_CYC cycles.
REQ-027 At the end of GAP, the block SHALL re-arbitrate on the current req: the winner gets OWN, or the state becomes IDLE if req = 0.
REQ-028 With DISP_ARB_GAP_EN defined, requests arriving during GAP SHALL NOT shorten the gap.
REQ-029 With DISP_ARB_GAP_EN undefined, the GAP state, its counter and GAP_CYC SHALL be unused, and switching SHALL be direct (REQ-021).

Verification (MIN_HOLD=8, GAP_CYC=2)
REQ-030 Reset/idle scenario: sw low, then high, req=0 for 20 cycles -> grant=0, busy=0, numbersData=FFFFFFFF, matrixData=0, beep=0 throughout.
REQ-031 Priority scenario: req=3'b110 set at edge k -> grant=3'b010 after edge k; matrixData==matrix1 in the same cycle.
REQ-032 Preempt scenario: source 2 owns, req0 rises at hold count 3 -> no switch until hold count reaches 8, then grant=001; with gap enabled, 2 blank cycles precede grant=001.
REQ-033 Release scenario: source 0 owns, req0 drops at hold count 2 with req2 high -> grant=100 after that edge (gap undefined) or after 2 blank cycles (gap defined).
REQ-034 Simultaneous scenario: source 1 owns, req1 falls and req0 rises in the same cycle -> treated as release; next owner is source 0 directly, hold counter 0.
REQ-035 Reset mid-operation scenario: sw pulsed low mid-GAP or mid-OWN -> grant=0 and outputs blank asynchronously; after release with req=010, grant=010 on the first edge.
